// File: rtl/pipe_pkg.sv
// Shared types and bundle widths for the pipeline stage registers.
// Skid FSM states plus payload widths of each inter-stage bundle.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_st_e;

  localparam int XLEN   = 32;
  localparam int REG_W  = 5;
  localparam int CTRL_W = 6;
  localparam int F7_W   = 7;
  localparam int F3_W   = 3;

  // pc + instr
  localparam int IF_ID_W  = XLEN + XLEN;
  // ctrl+imm+rs1+rs2+rd+funct7+funct3+valA+valB = 127
  localparam int ID_EX_W  = CTRL_W + XLEN + 3 * REG_W
                          + F7_W + F3_W + 2 * XLEN;
  // ctrl+alu result+store data+rd+funct3
  localparam int EX_MEM_W = CTRL_W + 2 * XLEN + REG_W + F3_W;
  // ctrl+writeback data+rd
  localparam int MEM_WB_W = CTRL_W + XLEN + REG_W;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins).
// Ports: clk, rst (async high), clr, inc, cnt[W-1:0].
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with optional two-entry skid buffer,
// flush and saturating stall counter.
// Ports: clk, rst (async high), flush, in_valid/in_ready/in_data,
//        out_valid/out_ready/out_data, cnt_clr, stall_cnt.
module pipe_stage_reg #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned SKID         = 0,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned CLR_ON_FLUSH = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  import pipe_pkg::*;

  skid_st_e          st_q;
  skid_st_e          st_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_q;
  logic [DATA_W-1:0] skid_d;
  logic              in_xfer;
  logic              out_xfer;

  assign out_valid = (st_q != ST_EMPTY);
  assign out_data  = main_q;

  // SKID=1: ready depends only on state, so no comb path
  // from out_ready. The rst term holds ready low in reset.
  if (SKID != 0) begin : g_skid_rdy
    assign in_ready = ~rst & (st_q != ST_FULL);
  end else begin : g_comb_rdy
    assign in_ready = ~rst & (~out_valid | out_ready);
  end

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // With SKID=0 the ONE state never sees in_xfer without
  // out_xfer, so FULL is unreachable and the same FSM applies.
  always_comb begin
    st_d   = st_q;
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      st_d = ST_EMPTY;
      if (CLR_ON_FLUSH != 0) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      unique case (st_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_d = in_data;
            st_d   = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
          end else if (in_xfer) begin
            skid_d = in_data;
            st_d   = ST_FULL;
          end else if (out_xfer) begin
            st_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            main_d = skid_q;
            st_d   = ST_ONE;
          end
        end
        default: begin
          st_d = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= ST_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      st_q   <= st_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (out_valid & ~out_ready),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: unit 0 is SKID=0/CNT_W=16/no clear,
// unit 1 is SKID=1/CNT_W=3/CLR_ON_FLUSH=1, checked against a queue model.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  in_valid;
  logic [1:0]  out_ready;
  logic [1:0]  flush;
  logic [1:0]  cnt_clr;
  logic [31:0] in_data [2];
  logic [1:0]  in_ready;
  logic [1:0]  out_valid;
  logic [31:0] out_data [2];
  logic [15:0] st_cnt0;
  logic [2:0]  st_cnt1;

  int nvec  = 0;
  int nfail = 0;
  bit chk_en = 0;

  // model: FIFO contents, last head seen, stall count
  logic [31:0] mq [2][2];
  int          mn [2]    = '{0, 0};
  logic [31:0] mhead [2] = '{32'h0, 32'h0};
  int          mcnt [2]  = '{0, 0};

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W(32), .SKID(0), .CNT_W(16), .CLR_ON_FLUSH(0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]),
    .cnt_clr(cnt_clr[0]), .stall_cnt(st_cnt0)
  );

  pipe_stage_reg #(
    .DATA_W(32), .SKID(1), .CNT_W(3), .CLR_ON_FLUSH(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]),
    .cnt_clr(cnt_clr[1]), .stall_cnt(st_cnt1)
  );

  function automatic bit m_ready(int k);
    if (rst) return 1'b0;
    if (k == 1) return mn[k] < 2;
    return (mn[k] == 0) || out_ready[k];
  endfunction

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s @%0t: got %h, want %h", nm, $time, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk or posedge rst) begin
    bit rdy;
    bit v;
    bit ixf;
    bit oxf;
    int cmax;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        mn[k]    = 0;
        mhead[k] = 32'h0;
        mcnt[k]  = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        rdy  = m_ready(k);
        v    = mn[k] > 0;
        ixf  = in_valid[k] && rdy;
        oxf  = v && out_ready[k];
        cmax = (k == 0) ? 65535 : 7;
        if (cnt_clr[k]) mcnt[k] = 0;
        else if (v && !out_ready[k] && mcnt[k] < cmax) mcnt[k]++;
        if (oxf) begin
          mq[k][0] = mq[k][1];
          mn[k]--;
        end
        if (flush[k]) begin
          mn[k] = 0;
          if (k == 1) mhead[k] = 32'h0;
        end else if (ixf) begin
          mq[k][mn[k]] = in_data[k];
          mn[k]++;
        end
        if (mn[k] > 0) mhead[k] = mq[k][0];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("u%0d_out_valid", k),
              32'(out_valid[k]), 32'(mn[k] > 0));
        check($sformatf("u%0d_out_data", k), out_data[k],
              (mn[k] > 0) ? mq[k][0] : mhead[k]);
        check($sformatf("u%0d_in_ready", k),
              32'(in_ready[k]), 32'(m_ready(k)));
        check($sformatf("u%0d_stall_cnt", k),
              (k == 0) ? 32'(st_cnt0) : 32'(st_cnt1),
              32'(mcnt[k]));
      end
    end
  end

  initial begin
    in_valid  = 2'b00;
    out_ready = 2'b00;
    flush     = 2'b00;
    cnt_clr   = 2'b00;
    in_data[0] = 32'h0;
    in_data[1] = 32'h0;

    // reset held 12 ns with a valid word on the inputs
    #1;
    rst = 1'b1;
    chk_en = 1;
    in_valid = 2'b11;
    in_data[0] = 32'hAAAABBBB;
    in_data[1] = 32'hAAAABBBB;
    for (int t = 0; t < 3; t++) begin
      #3;
      for (int k = 0; k < 2; k++) begin
        check("rst_out_valid", 32'(out_valid[k]), 32'h0);
        check("rst_out_data", out_data[k], 32'h0);
        check("rst_in_ready", 32'(in_ready[k]), 32'h0);
      end
      check("rst_stall0", 32'(st_cnt0), 32'h0);
      check("rst_stall1", 32'(st_cnt1), 32'h0);
    end
    #3;
    rst = 1'b0;
    in_valid = 2'b00;
    #1;
    check("post_rst_rdy1", 32'(in_ready[1]), 32'h1);
    check("post_rst_rdy0", 32'(in_ready[0]), 32'h1);
    step();
    check("post_rst_empty0", 32'(out_valid[0]), 32'h0);
    check("post_rst_empty1", 32'(out_valid[1]), 32'h0);

    // unit 0 streaming 1,2,3
    out_ready[0] = 1'b1;
    in_valid[0] = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data[0] = 32'(i);
      step();
      check("s0_stream_data", out_data[0], 32'(i));
      check("s0_stream_rdy", 32'(in_ready[0]), 32'h1);
    end
    in_valid[0] = 1'b0;
    step();
    check("s0_stream_drain", 32'(out_valid[0]), 32'h0);

    // unit 0 backpressure
    out_ready[0] = 1'b0;
    in_valid[0] = 1'b1;
    in_data[0] = 32'h7;
    step();
    check("s0_bp_hold_rdy", 32'(in_ready[0]), 32'h0);
    in_data[0] = 32'h8;
    step();
    check("s0_bp_hold_data", out_data[0], 32'h7);
    out_ready[0] = 1'b1;
    step();
    check("s0_bp_pass", out_data[0], 32'h8);
    in_valid[0] = 1'b0;
    step();

    // unit 0 flush keeps data (no clear)
    out_ready[0] = 1'b0;
    in_valid[0] = 1'b1;
    in_data[0] = 32'h9;
    step();
    flush[0] = 1'b1;
    in_data[0] = 32'hA;
    step();
    flush[0] = 1'b0;
    in_valid[0] = 1'b0;
    check("s0_flush_valid", 32'(out_valid[0]), 32'h0);
    check("s0_flush_keep", out_data[0], 32'h9);

    // unit 1 skid backpressure
    out_ready[1] = 1'b0;
    in_valid[1] = 1'b1;
    in_data[1] = 32'h11111111;
    step();
    check("s1_one_data", out_data[1], 32'h11111111);
    check("s1_one_rdy", 32'(in_ready[1]), 32'h1);
    in_data[1] = 32'h22222222;
    step();
    check("s1_full_rdy", 32'(in_ready[1]), 32'h0);
    in_data[1] = 32'hDEADBEEF;
    step();
    step();
    check("s1_full_hold", out_data[1], 32'h11111111);
    check("s1_no_accept", 32'(in_ready[1]), 32'h0);
    out_ready[1] = 1'b1;
    step();
    check("s1_out2", out_data[1], 32'h22222222);
    step();
    check("s1_out3", out_data[1], 32'hDEADBEEF);
    in_valid[1] = 1'b0;
    step();
    check("s1_drain", 32'(out_valid[1]), 32'h0);

    // unit 1 flush while FULL
    out_ready[1] = 1'b0;
    in_valid[1] = 1'b1;
    in_data[1] = 32'hA1;
    step();
    in_data[1] = 32'hA2;
    step();
    in_data[1] = 32'hBAD00BAD;
    flush[1] = 1'b1;
    step();
    flush[1] = 1'b0;
    in_valid[1] = 1'b0;
    check("s1_flush_valid", 32'(out_valid[1]), 32'h0);
    check("s1_flush_data", out_data[1], 32'h0);
    in_valid[1] = 1'b1;
    in_data[1] = 32'h00C0FFEE;
    step();
    check("s1_after_flush", out_data[1], 32'h00C0FFEE);
    in_valid[1] = 1'b0;
    out_ready[1] = 1'b1;
    step();
    flush[1] = 1'b1;
    in_valid[1] = 1'b1;
    in_data[1] = 32'hBAD1;
    step();
    flush[1] = 1'b0;
    in_valid[1] = 1'b0;
    check("s1_flush_empty", 32'(out_valid[1]), 32'h0);
    check("s1_flush_clr", out_data[1], 32'h0);

    // unit 1 stall counter saturation and clear
    out_ready[1] = 1'b0;
    cnt_clr[1] = 1'b1;
    in_valid[1] = 1'b1;
    in_data[1] = 32'h55;
    step();
    check("cnt_start", 32'(st_cnt1), 32'h0);
    cnt_clr[1] = 1'b0;
    in_valid[1] = 1'b0;
    repeat (10) step();
    check("cnt_sat", 32'(st_cnt1), 32'h7);
    cnt_clr[1] = 1'b1;
    step();
    check("cnt_clr", 32'(st_cnt1), 32'h0);
    cnt_clr[1] = 1'b0;
    step();
    check("cnt_after_clr", 32'(st_cnt1), 32'h1);

    // async reset mid-cycle while FULL
    in_valid[1] = 1'b1;
    in_data[1] = 32'h66;
    step();
    in_valid[1] = 1'b0;
    check("ar_full", 32'(in_ready[1]), 32'h0);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid1", 32'(out_valid[1]), 32'h0);
    check("ar_data1", out_data[1], 32'h0);
    check("ar_rdy1", 32'(in_ready[1]), 32'h0);
    check("ar_cnt1", 32'(st_cnt1), 32'h0);
    check("ar_data0", out_data[0], 32'h0);
    step();
    step();
    rst = 1'b0;
    step();
    check("ar_end0", 32'(out_valid[0]), 32'h0);
    check("ar_end1", 32'(out_valid[1]), 32'h0);

    #2;
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
